// File: rtl/ccff_loader.sv
// Configuration-chain loader: serializes host bitstream words MSB-first onto the eFPGA ccff chain.
// Optional readback compare of ccff_tail in verify passes is enabled by defining CCFF_READBACK_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; no pass in progress
// S_FETCH  | in_ready high, waiting for the next host word
// S_SHIFT  | one chain bit per cycle, ccff_shift_en high
// S_FINISH | chain full; done pulses for one cycle
module ccff_loader #(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_SHIFT  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode;
  logic              r_head;
  logic              r_shift_en;
  logic              w_accept;
  logic              w_last_bit;
  logic              w_word_end;

  assign w_accept   = (r_state == S_FETCH) && in_valid;
  assign w_last_bit = (r_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_word_end = (r_idx == '0);
  assign w_idx_nxt  = r_idx - IDX_W'(1);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = S_FINISH;
        end else if (w_word_end) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Head and shift-enable are loaded one cycle ahead so they line up with the SHIFT cycles.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_shreg    <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
    end else begin
      r_shift_en <= (w_state_nxt == S_SHIFT);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= verify;
            r_cnt  <= '0;
          end
        end
        S_FETCH: begin
          if (w_accept) begin
            r_shreg <= in_data;
            r_idx   <= IDX_W'(DATA_W - 1);
            r_head  <= in_data[DATA_W-1];
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!w_last_bit && !w_word_end) begin
            r_idx  <= w_idx_nxt;
            r_head <= r_shreg[w_idx_nxt];
          end else begin
            r_head <= 1'b0;
          end
        end
        default: r_head <= 1'b0;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic r_err;

  // The tail replays the previous pass's bit k at verify shift k, so it must equal the head.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_err <= 1'b0;
    end else if (r_mode && r_shift_en && (ccff_tail != r_head)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused;

  assign w_unused = ^{ccff_tail, r_mode};
  assign err      = 1'b0;
`endif

  assign in_ready      = (r_state == S_FETCH);
  assign busy          = (r_state == S_FETCH) || (r_state == S_SHIFT);
  assign done          = (r_state == S_FINISH);
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader for the eFPGA fabric. It accepts bitstream words from the host-side programming interface over a valid/ready handshake and serializes them MSB-first onto the `ccff_head` input of the first tile in the configuration flip-flop chain. It counts exactly `CHAIN_LEN` shifts per pass and emits a shift-enable that qualifies the external gated chain clock. It sits directly upstream of the I/O and logic tiles, whose `ccff_head`/`ccff_tail` ports form the chain.

## Interface
Parameters:
- `DATA_W`, 8, bitstream word width from the host.
- `CHAIN_LEN`, 1024, total configuration bits in the chain (≥ 1).
- `CNT_W`, $clog2(CHAIN_LEN+1), shift-counter width.

Ports:
- `prog_clk` input 1: programming clock. All state is on its rising edge.
- `pReset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a pass. Ignored unless the FSM is in IDLE.
- `verify` input 1: sampled with `start`. 0 selects a program pass, 1 selects a verify pass.
- `in_valid` input 1: host word valid.
- `in_data` input DATA_W: host word, MSB shifted first.
- `in_ready` output 1: loader can accept a word.
- `ccff_head` output 1: serial data into the chain. Registered.
- `ccff_shift_en` output 1: the chain advances on each `prog_clk` edge where this is 1. Drives the external clock gate.
- `ccff_tail` input 1: last bit of the chain, used for readback.
- `busy` output 1: a pass is in progress.
- `done` output 1: one-cycle pulse when a pass completes.
- `err` output 1: sticky verify mismatch, cleared by `start`.

## Operation
FSM states are IDLE, FETCH, SHIFT and FINISH.
- **IDLE**
  - `in_ready` = 0, `busy` = 0.
  - On `start`: latch `verify` into `mode`, clear the bit counter and `err`, go to FETCH.
- **FETCH**
  - `in_ready` = 1, `busy` = 1.
  - On `in_valid && in_ready`: load `in_data` into the shift register, set the word bit index to DATA_W-1, go to SHIFT.
- **SHIFT**
  - `ccff_head` is updated to `shreg[idx]` and `ccff_shift_en` = 1 each cycle. The bit counter increments each cycle.
  - After the last bit of the word, with count < CHAIN_LEN: go to FETCH.
  - When the count reaches CHAIN_LEN: go to FINISH.
  - Remaining low-order bits of the final word are discarded. Words per pass = ceil(CHAIN_LEN/DATA_W).
- **FINISH**
  - `ccff_shift_en` = 0. `done` pulses for one cycle. Go to IDLE.
- Only complete handshakes consume words. `in_valid` while not in FETCH is ignored.
- `start` during a pass is ignored.
- `pReset` mid-pass:
  - All outputs return to reset values immediately and the FSM returns to IDLE.
  - Chain contents are then undefined; the host must rerun a full program pass.

## Timing
- Reset values: `in_ready` = 0, `ccff_head` = 0, `ccff_shift_en` = 0, `busy` = 0, `done` = 0, `err` = 0.
- `ccff_head` and `ccff_shift_en` are registered and change together. The chain captures `ccff_head` on the next `prog_clk` edge while `ccff_shift_en` = 1.
- Handshake to first shift-enable: 1 cycle.
- Back-to-back words have a 1-cycle FETCH bubble (`ccff_shift_en` = 0) even if `in_valid` is held high.
- Pass length with `in_valid` always high: 1 (start→FETCH) + W × 1 (FETCH) + CHAIN_LEN (SHIFT) + 1 (FINISH), where W = words per pass.
- `done` is asserted in the cycle after the final shift-enable. `busy` falls in the same cycle that `done` pulses.

## Configuration
`CCFF_READBACK_EN`
- **Defined:** in a verify pass, on every cycle with `ccff_shift_en` = 1, `ccff_tail` is compared with the current `ccff_head`. Any inequality sets `err`, which holds until the next `start`. This works because the host resends the identical bitstream, so the tail emits the previous pass's bit k at verify shift k.
- **Not defined:** `verify` is treated as a program pass, `err` is tied to 0, and `ccff_tail` is unused.

## Test plan
With CHAIN_LEN = 20 and DATA_W = 8, using a 20-bit shift-register chain model:
- **Program pass:** `start` with `verify` = 0, words 0xA5, 0x3C, 0xF0 → exactly 20 shift-enables. Chain holds 1010_0101_0011_1100_1111 (first bit deepest). Low nibble of 0xF0 is discarded. `done` pulses once.
- **Throttled host:** `in_valid` low for 5 cycles between words → `ccff_shift_en` stays 0 during the gaps and the final chain contents are identical.
- **Verify pass (macro on):** program, then verify with the same words → `err` = 0. Repeat verify with the second word 0x3D → `err` = 1 and stays 1 after `done`.
- **Reset mid-pass:** assert `pReset` after 10 shifts → all outputs 0 and state IDLE. A following full program pass gives correct chain contents.
- **Stray inputs:** `start` during SHIFT, and `in_valid` in IDLE → both ignored, with no extra shifts or words consumed.
